// File: rtl/osfm_ctrl_pkg.sv
// Shared definitions for the OSFM dot-product controller slice.
`ifndef OSFM_BITWIDTH_I
`define OSFM_BITWIDTH_I 8
`endif

package osfm_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} osfm_dot_state_t;

  // Default accumulator width: full product plus one bit per doubling of length.
  function automatic int osfm_acc_w(input int bitwidth, input int len_w);
    return 2 * bitwidth + len_w;
  endfunction

endpackage

// File: rtl/osfm_dot_ctrl_if.sv
// Job, operand-stream and result handshake bundle of the dot-product controller.
interface osfm_dot_ctrl_if #(
  parameter int BITWIDTH = `OSFM_BITWIDTH_I,
  parameter int LEN_W    = 8,
  parameter int ACC_W    = osfm_ctrl_pkg::osfm_acc_w(BITWIDTH, LEN_W)
);
  logic                start;
  logic [LEN_W-1:0]    vec_len;
  logic                busy;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_a;
  logic [BITWIDTH-1:0] in_b;
  logic                res_valid;
  logic                res_ready;
  logic [ACC_W-1:0]    res_data;
  logic                overflow;

  // Operand fetch / result consumer side
  modport master (
    output start, vec_len, in_valid, in_a, in_b, res_ready,
    input  busy, in_ready, res_valid, res_data, overflow
  );

  // Controller side
  modport slave (
    input  start, vec_len, in_valid, in_a, in_b, res_ready,
    output busy, in_ready, res_valid, res_data, overflow
  );
endinterface

// File: rtl/osfm_mac_pipe.sv
// Product capture and accumulation stages behind the external multiplier.
module osfm_mac_pipe import osfm_ctrl_pkg::*; #(
  parameter int P_W   = 16,
  parameter int LEN_W = 8,
  parameter int ACC_W = osfm_acc_w(P_W / 2, LEN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vld_p1,
  input  logic [P_W-1:0]   prod_p1,
  input  logic [LEN_W-1:0] len,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             ret_last
);

  logic [P_W-1:0]   prod_p2;
  logic             vld_p2;
  logic [LEN_W-1:0] ret_cnt;
  logic [LEN_W-1:0] ret_nxt;
  logic [ACC_W:0]   sum_p2;

  // Unsigned accumulate; the extra top bit is the carry out of the accumulator.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [P_W-1:0]   p);
    return {1'b0, a} + (ACC_W+1)'(p);
  endfunction

  assign sum_p2   = acc_add(acc, prod_p2);
  assign ret_nxt  = ret_cnt + 1'b1;
  assign ret_last = vld_p2 && (ret_nxt == len);

  // Stage 2: capture the multiplier product (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (vld_p1) prod_p2 <= prod_p1;
  end

  // Stage 2 valid; reset flushes any in-flight product
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  // Stage 3: accumulate, count retired products, latch sticky carry
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc     <= '0;
      ovf     <= 1'b0;
      ret_cnt <= '0;
    end else if (vld_p2) begin
      acc     <= sum_p2[ACC_W-1:0];
      ovf     <= ovf | sum_p2[ACC_W];
      ret_cnt <= ret_nxt;
    end
  end

endmodule

// File: rtl/osfm_dot_ctrl.sv
// Dot-product sequencer: feeds operand pairs to the shared OSFM multiplier
// and returns one accumulated sum per job.
module osfm_dot_ctrl import osfm_ctrl_pkg::*; #(
  parameter int BITWIDTH = `OSFM_BITWIDTH_I,
  parameter int LEN_W    = 8,
  parameter int ACC_W    = osfm_acc_w(BITWIDTH, LEN_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  osfm_dot_ctrl_if.slave        bus,
  output logic [BITWIDTH-1:0]   mul_a,
  output logic [BITWIDTH-1:0]   mul_b,
  input  logic [2*BITWIDTH-1:0] mul_p
);

  osfm_dot_state_t  state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] issue_nxt;
  logic             issue_hs;
  logic             job_clr;
  logic             vld_p1;
  logic             ret_last;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  assign issue_hs  = (state == RUN) && bus.in_valid;
  assign job_clr   = (state == IDLE) && bus.start;
  assign issue_nxt = issue_cnt + 1'b1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b1;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = (bus.vec_len != '0) ? RUN : DONE;
      end
      RUN: begin
        bus.in_ready = 1'b1;
        if (issue_hs && (issue_nxt == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ret_last) state_nxt = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job length latch and issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      issue_cnt <= '0;
    end else if (job_clr) begin
      len_q     <= bus.vec_len;
      issue_cnt <= '0;
    end else if (issue_hs) begin
      issue_cnt <= issue_nxt;
    end
  end

  // Stage 1: operand registers hold between handshakes so the multiplier stays quiet
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a  <= '0;
      mul_b  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue_hs;
      if (issue_hs) begin
        mul_a <= bus.in_a;
        mul_b <= bus.in_b;
      end
    end
  end

  osfm_mac_pipe #(
    .P_W   (2 * BITWIDTH),
    .LEN_W (LEN_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (job_clr),
    .vld_p1   (vld_p1),
    .prod_p1  (mul_p),
    .len      (len_q),
    .acc      (acc),
    .ovf      (ovf),
    .ret_last (ret_last)
  );

  assign bus.res_data = acc;
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_osfm_dot_ctrl.sv
// Bench for osfm_dot_ctrl: transaction-level model plus directed job scenarios.
module tb_osfm_dot_ctrl;

  localparam int  BW    = 8;
  localparam int  LW    = 8;
  localparam int  AW    = 24;
  localparam int  AW_S  = 16;
  localparam longint ACC_MOD = longint'(1) << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  osfm_dot_ctrl_if #(.BITWIDTH(BW), .LEN_W(LW), .ACC_W(AW))   ifm();
  osfm_dot_ctrl_if #(.BITWIDTH(BW), .LEN_W(LW), .ACC_W(AW_S)) ifs();

  logic [BW-1:0]   mul_a_m, mul_b_m, mul_a_s, mul_b_s;
  logic [2*BW-1:0] mul_p_m, mul_p_s;

  // Exact multiplier stand-ins
  assign mul_p_m = mul_a_m * mul_b_m;
  assign mul_p_s = mul_a_s * mul_b_s;

  osfm_dot_ctrl #(.BITWIDTH(BW), .LEN_W(LW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(ifm), .mul_a(mul_a_m), .mul_b(mul_b_m), .mul_p(mul_p_m)
  );

  osfm_dot_ctrl #(.BITWIDTH(BW), .LEN_W(LW), .ACC_W(AW_S)) dut_s (
    .clk(clk), .rst(rst), .bus(ifs), .mul_a(mul_a_s), .mul_b(mul_b_s), .mul_p(mul_p_s)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model of the main instance
  bit          chk_en   = 1'b0;
  bit          job_open = 1'b0;
  bit          clean    = 1'b1;
  int          m_len    = 0;
  int          m_issued = 0;
  longint      m_sum    = 0;
  int          res_from = -1;
  logic [7:0]  last_a   = '0;
  logic [7:0]  last_b   = '0;

  initial begin
    forever begin
      bit exp_rdy, exp_rv;
      @(negedge clk);
      cyc++;
      exp_rdy = job_open && (m_issued < m_len);
      exp_rv  = job_open && (res_from >= 0) && (cyc >= res_from);
      if (chk_en) begin
        chk("busy",      ifm.busy,      job_open);
        chk("in_ready",  ifm.in_ready,  exp_rdy);
        chk("res_valid", ifm.res_valid, exp_rv);
        chk("mul_a",     mul_a_m,       last_a);
        chk("mul_b",     mul_b_m,       last_b);
        if (exp_rv || clean) begin
          chk("res_data", ifm.res_data, m_sum % ACC_MOD);
          chk("overflow", ifm.overflow, m_sum >= ACC_MOD);
        end
      end
      if (rst) begin
        chk_en = 1'b1; job_open = 1'b0; clean = 1'b1; m_len = 0; m_issued = 0;
        m_sum = 0; res_from = -1; last_a = '0; last_b = '0;
      end else begin
        if (!job_open && ifm.start) begin
          job_open = 1'b1; clean = 1'b0; m_len = int'(ifm.vec_len);
          m_issued = 0; m_sum = 0;
          res_from = (m_len == 0) ? cyc + 1 : -1;
        end else if (exp_rdy && ifm.in_valid) begin
          m_issued++;
          m_sum += longint'(ifm.in_a) * longint'(ifm.in_b);
          last_a = ifm.in_a;
          last_b = ifm.in_b;
          if (m_issued == m_len) res_from = cyc + 3;
        end
        if (exp_rv && ifm.res_ready) begin
          job_open = 1'b0;
          res_from = -1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    ifm.start   = 1'b1;
    ifm.vec_len = 8'(len);
    tick();
    ifm.start   = 1'b0;
  endtask

  task automatic send(input int a, input int b);
    int n = 0;
    ifm.in_valid = 1'b1;
    ifm.in_a     = 8'(a);
    ifm.in_b     = 8'(b);
    while (!ifm.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("send_wait", ifm.in_ready, 1);
    tick();
    ifm.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (!ifm.res_valid && n < 30) begin
      tick();
      n++;
    end
    chk(name, ifm.res_valid, 1);
  endtask

  task automatic consume;
    ifm.res_ready = 1'b1;
    tick();
    ifm.res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] opa [3] = '{8'd10, 8'd30, 8'd50};
  logic [7:0] opb [3] = '{8'd20, 8'd40, 8'd60};
  bit         pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int idx;
    int n;
    rst = 1'b1;
    ifm.start = 0; ifm.vec_len = 0; ifm.in_valid = 0; ifm.in_a = 0; ifm.in_b = 0; ifm.res_ready = 0;
    ifs.start = 0; ifs.vec_len = 0; ifs.in_valid = 0; ifs.in_a = 0; ifs.in_b = 0; ifs.res_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_res_data", ifm.res_data, 0);
    chk("reset_busy", ifm.busy, 0);
    tick();

    // Four pairs back to back: 2+12+30+56 = 100
    start_job(4);
    send(1, 2); send(3, 4); send(5, 6); send(7, 8);
    chk("t1_rv_t1", ifm.res_valid, 0);
    tick();
    chk("t1_rv_t2", ifm.res_valid, 0);
    tick();
    chk("t1_rv_t3", ifm.res_valid, 1);
    chk("t1_data", ifm.res_data, 100);
    chk("t1_ovf", ifm.overflow, 0);
    consume();

    // Zero-length job
    start_job(0);
    chk("t2_rv", ifm.res_valid, 1);
    chk("t2_data", ifm.res_data, 0);
    chk("t2_in_ready", ifm.in_ready, 0);
    consume();

    // Gapped stream, held result: 200+1200+3000 = 4400
    start_job(3);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (pat[c]) begin
        ifm.in_valid = 1'b1; ifm.in_a = opa[idx]; ifm.in_b = opb[idx];
        idx++;
      end else begin
        ifm.in_valid = 1'b0;
      end
      tick();
    end
    ifm.in_valid = 1'b0;
    wait_res("t3_rv");
    for (int c = 0; c < 10; c++) begin
      chk("t3_hold_data", ifm.res_data, 4400);
      chk("t3_hold_busy", ifm.busy, 1);
      tick();
    end
    consume();
    chk("t3_busy_after", ifm.busy, 0);

    // Narrow accumulator wraps: 2*65025 mod 65536 = 64514 with carry
    ifs.start = 1'b1; ifs.vec_len = 8'd2;
    tick();
    ifs.start = 1'b0;
    chk("t4_in_ready", ifs.in_ready, 1);
    chk("t4_busy", ifs.busy, 1);
    ifs.in_valid = 1'b1; ifs.in_a = 8'd255; ifs.in_b = 8'd255;
    tick(); tick();
    ifs.in_valid = 1'b0;
    n = 0;
    while (!ifs.res_valid && n < 30) begin tick(); n++; end
    chk("t4_rv", ifs.res_valid, 1);
    chk("t4_data", ifs.res_data, 64514);
    chk("t4_ovf", ifs.overflow, 1);
    ifs.res_ready = 1'b1; tick(); ifs.res_ready = 1'b0;
    ifs.start = 1'b1; ifs.vec_len = 8'd1;
    tick();
    ifs.start = 1'b0;
    chk("t4_ovf_cleared", ifs.overflow, 0);
    ifs.in_valid = 1'b1; ifs.in_a = 8'd2; ifs.in_b = 8'd3;
    tick();
    ifs.in_valid = 1'b0;
    n = 0;
    while (!ifs.res_valid && n < 30) begin tick(); n++; end
    chk("t4b_data", ifs.res_data, 6);
    chk("t4b_ovf", ifs.overflow, 0);
    ifs.res_ready = 1'b1; tick(); ifs.res_ready = 1'b0;

    // Reset while draining, then a fresh job: 9*9 = 81
    start_job(4);
    send(11, 12); send(13, 14); send(15, 16); send(17, 18);
    chk("t5_busy_drain", ifm.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", ifm.busy, 0);
    chk("t5_in_ready", ifm.in_ready, 0);
    chk("t5_rv", ifm.res_valid, 0);
    chk("t5_data", ifm.res_data, 0);
    chk("t5_ovf", ifm.overflow, 0);
    chk("t5_mul_a", mul_a_m, 0);
    chk("t5_mul_b", mul_b_m, 0);
    repeat (4) tick();
    chk("t5_rv_idle", ifm.res_valid, 0);
    start_job(1);
    send(9, 9);
    wait_res("t5b_rv");
    chk("t5b_data", ifm.res_data, 81);
    consume();

    // start during RUN is ignored: 6+20+42 = 68
    start_job(3);
    send(2, 3);
    ifm.start = 1'b1; ifm.vec_len = 8'd1;
    send(4, 5);
    ifm.start = 1'b0;
    chk("t6_in_ready", ifm.in_ready, 1);
    send(6, 7);
    wait_res("t6_rv");
    chk("t6_data", ifm.res_data, 68);
    consume();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osfm_dot_ctrl.md
# osfm_dot_ctrl

Sequencing controller that streams operand pairs through the shared combinational OSFM approximate multiplier (partial-product generation, column accumulation and final adder, instantiated by the parent) and accumulates a dot product of programmable length. It sits between the DNN layer's operand fetch logic and the multiplier, adds register stages around the multiplier's combinational path, and returns one accumulated result per job over a valid/ready handshake.

## Interface
Parameters:
- BITWIDTH, default `OSFM_BITWIDTH_I: operand width; must match the multiplier instance.
- LEN_W, default 8: width of the vector-length field.
- ACC_W, default 2*BITWIDTH+LEN_W: accumulator width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- vec_len  in  LEN_W  number of operand pairs; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid&&in_ready.
- in_a, in_b  in  BITWIDTH each  operands, unsigned.
- mul_a, mul_b  out  BITWIDTH each  registered operands to the multiplier.
- mul_p  in  2*BITWIDTH  combinational multiplier product.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid&&res_ready.
- res_data  out  ACC_W  accumulated sum.
- overflow  out  1  sticky carry-out of the accumulator for the current job.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. If start and vec_len!=0: latch the length, clear acc, issue count, retire count and overflow, then go to RUN. If start and vec_len==0: clear acc and go directly to DONE (res_data=0).
- RUN: in_ready=1. Each handshake loads mul_a/mul_b, sets s1_vld and increments the issue count. The handshake that brings the issue count to len moves the FSM to DRAIN, and in_ready drops in the next cycle.
- mul_a/mul_b hold their last value when there is no handshake, so the multiplier does not toggle needlessly.
- Stage 2: if s1_vld, p_reg<=mul_p. s2_vld<=s1_vld.
- Stage 3: if s2_vld, acc<=acc+zero-extended p_reg and the retire count increments. A carry out of ACC_W bits sets overflow (sticky), and acc wraps modulo 2^ACC_W.
- DRAIN: in_ready=0. When the retire update brings the count to len, the FSM goes to DONE on the same edge.
- DONE: res_valid=1. res_data=acc and overflow hold stable until res_ready. On the handshake the FSM returns to IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored.

## Timing
- Reset values: FSM=IDLE, busy=0, in_ready=0, res_valid=0, res_data=0, overflow=0, mul_a=mul_b=0, s1_vld=s2_vld=0, all counts 0.
- rst mid-job aborts the job immediately: pipeline valids are flushed and no result is produced.
- Throughput is one pair per cycle.
- Handshake in cycle t gives mul_a/mul_b valid in t+1, p_reg in t+2 and acc updated at the end of t+2.
- res_valid is first high in cycle t+3, where t is the cycle of the final handshake.
- res_valid held with res_ready low keeps res_data constant indefinitely.
- start sampled at cycle s gives in_ready=1 from cycle s+1.
- A job with vec_len==0 has res_valid=1 in cycle s+1.
- After the res handshake, the earliest next start is accepted in the following cycle, when the FSM is in IDLE.
- Gaps in in_valid during RUN stall issue only; in-flight products still retire.

## Structure
- Shared package osfm_ctrl_pkg holds:
  - typedef enum logic [1:0] osfm_dot_state_t {IDLE, RUN, DRAIN, DONE};
  - the ACC_W default expression.
- One sub-module, osfm_mac_pipe, contains p_reg, s2_vld, the accumulator, the retire counter and overflow detection.
- osfm_dot_ctrl contains the FSM, the issue counter and the operand registers.
- The multiplier stays outside this block.

## Test plan
- BITWIDTH=8: vec_len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, with the multiplier modeled exactly -> res_data=100, res_valid in the 3rd cycle after the last handshake, overflow=0.
- vec_len=0 -> res_valid in the cycle after start, res_data=0, and in_ready never asserted.
- vec_len=3, in_valid toggling 1,0,0,1,0,1 and res_ready held low for 10 cycles -> res_data=sum of the three products, stable throughout, busy=1 until the res handshake.
- ACC_W forced to 16 with vec_len=2, pairs (255,255),(255,255) -> res_data=(2*65025) mod 65536=64514, overflow=1. The next job clears overflow.
- rst pulsed while in DRAIN -> all outputs take their reset values the next cycle. A new job of vec_len=1 with (9,9) then yields 81.
- start asserted during RUN with a different vec_len -> the request is ignored and the current job completes with its original length.
